// File: rtl/tlb_pkg.sv
// Shared types for the TLB miss controller: entry layout and FSM encoding.
package tlb_pkg;

  localparam int TLB_VPN_W = 6;
  localparam int TLB_PPN_W = 2;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic                 ref_bit;
    logic [TLB_VPN_W-1:0] vpn;
    logic [TLB_PPN_W-1:0] ppn;
  } tlb_entry_t;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_RESP       = 2'd1;
  localparam logic [1:0] ST_WB_WAIT    = 2'd2;
  localparam logic [1:0] ST_FETCH_WAIT = 2'd3;

endpackage

// File: rtl/tlb_miss_controller_if.sv
// Page-table bus between the miss controller (master) and the page table (slave).
interface tlb_miss_controller_if #(
  parameter int VPN_W = 6,
  parameter int PPN_W = 2
);
  logic             read_write_PT;
  logic [VPN_W-1:0] virtual_page_tag;
  logic             dirty_write_back;
  logic             reference_write_back;
  logic [PPN_W-1:0] physical_page_tag;
  logic             page_fault;
  logic             PT_done;
  logic             dirty_fetched;
  logic             reference_fetched;

  modport master (
    output read_write_PT, virtual_page_tag, dirty_write_back, reference_write_back,
    input  physical_page_tag, page_fault, PT_done, dirty_fetched, reference_fetched
  );

  modport slave (
    input  read_write_PT, virtual_page_tag, dirty_write_back, reference_write_back,
    output physical_page_tag, page_fault, PT_done, dirty_fetched, reference_fetched
  );
endinterface

// File: rtl/pt_done_sync.sv
// Two-flop synchronizer for the page table's async done line, plus a rising-edge pulse.
module pt_done_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);
  // [0],[1] are the synchronizer; [2] holds the previous synced value for edge detect
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], async_in};
  end

  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/tlb_miss_controller.sv
// Fully-associative TLB with miss handling: dirty-victim write-back, then fetch from
// the page table, with a timeout on each page-table transaction.
module tlb_miss_controller
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 4,
  parameter int VPN_W       = TLB_VPN_W,
  parameter int PPN_W       = TLB_PPN_W,
  parameter int PT_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req_valid,
  input  logic             cpu_req_write,
  input  logic [VPN_W-1:0] cpu_vpn,
  input  logic             tlb_flush,
  output logic             cpu_req_ready,
  output logic             resp_valid,
  output logic [PPN_W-1:0] resp_ppn,
  output logic             resp_fault,
  output logic             resp_timeout,
  tlb_miss_controller_if.master pt
);
  localparam int IDX_W = $clog2(TLB_ENTRIES);

  tlb_entry_t             tlb [TLB_ENTRIES];
  logic [1:0]             state;
  logic [IDX_W-1:0]       rr, victim;
  logic [VPN_W-1:0]       req_vpn;
  logic                   req_wr;
  logic [7:0]             tmo_cnt;
  logic                   done_rise;

  logic [TLB_ENTRIES-1:0] hit_vec, inv_vec;
  logic [IDX_W-1:0]       hit_idx, inv_idx, victim_sel;
  logic                   hit, any_inv, tmo_hit;

  pt_done_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pt.PT_done),
    .rise     (done_rise)
  );

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_cam
    assign hit_vec[i] = tlb[i].valid && (tlb[i].vpn == cpu_vpn);
    assign inv_vec[i] = ~tlb[i].valid;
  end

  // Descending scan leaves the lowest matching index
  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
      if (inv_vec[i]) inv_idx = IDX_W'(i);
    end
  end

  assign hit        = |hit_vec;
  assign any_inv    = |inv_vec;
  assign victim_sel = any_inv ? inv_idx : rr;
  assign tmo_hit    = (tmo_cnt == 8'(PT_TIMEOUT - 1));

  // Ready is gated by reset so every output reads 0 while rst_n is low
  assign cpu_req_ready = rst_n & (state == ST_IDLE) & ~tlb_flush;
  assign resp_valid    = (state == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_IDLE;
      rr                      <= '0;
      victim                  <= '0;
      req_vpn                 <= '0;
      req_wr                  <= 1'b0;
      tmo_cnt                 <= '0;
      resp_ppn                <= '0;
      resp_fault              <= 1'b0;
      resp_timeout            <= 1'b0;
      pt.read_write_PT        <= 1'b0;
      pt.virtual_page_tag     <= '0;
      pt.dirty_write_back     <= 1'b0;
      pt.reference_write_back <= 1'b0;
      for (int i = 0; i < TLB_ENTRIES; i++) tlb[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tlb_flush) begin
            for (int i = 0; i < TLB_ENTRIES; i++) tlb[i].valid <= 1'b0;
          end else if (cpu_req_valid) begin
            req_vpn <= cpu_vpn;
            req_wr  <= cpu_req_write;
            if (hit) begin
              tlb[hit_idx].ref_bit <= 1'b1;
              if (cpu_req_write) tlb[hit_idx].dirty <= 1'b1;
              resp_ppn     <= tlb[hit_idx].ppn;
              resp_fault   <= 1'b0;
              resp_timeout <= 1'b0;
              state        <= ST_RESP;
            end else begin
              victim  <= victim_sel;
              tmo_cnt <= '0;
              if (!any_inv) rr <= rr + 1'b1;
              if (tlb[victim_sel].valid && tlb[victim_sel].dirty) begin
                pt.read_write_PT        <= 1'b1;
                pt.virtual_page_tag     <= tlb[victim_sel].vpn;
                pt.dirty_write_back     <= tlb[victim_sel].dirty;
                pt.reference_write_back <= tlb[victim_sel].ref_bit;
                state                   <= ST_WB_WAIT;
              end else begin
                pt.read_write_PT        <= 1'b0;
                pt.virtual_page_tag     <= cpu_vpn;
                pt.dirty_write_back     <= 1'b0;
                pt.reference_write_back <= 1'b0;
                state                   <= ST_FETCH_WAIT;
              end
            end
          end
        end
        ST_WB_WAIT: begin
          if (done_rise) begin
            tlb[victim].valid       <= 1'b0;
            pt.read_write_PT        <= 1'b0;
            pt.virtual_page_tag     <= req_vpn;
            pt.dirty_write_back     <= 1'b0;
            pt.reference_write_back <= 1'b0;
            tmo_cnt                 <= '0;
            state                   <= ST_FETCH_WAIT;
          end else if (tmo_hit) begin
            resp_ppn     <= '0;
            resp_fault   <= 1'b1;
            resp_timeout <= 1'b1;
            state        <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_FETCH_WAIT: begin
          if (done_rise) begin
            resp_timeout <= 1'b0;
            if (pt.page_fault) begin
              resp_ppn   <= '0;
              resp_fault <= 1'b1;
            end else begin
              tlb[victim] <= '{valid:   1'b1,
                               dirty:   pt.dirty_fetched | req_wr,
                               ref_bit: 1'b1,
                               vpn:     req_vpn,
                               ppn:     pt.physical_page_tag};
              resp_ppn   <= pt.physical_page_tag;
              resp_fault <= 1'b0;
            end
            state <= ST_RESP;
          end else if (tmo_hit) begin
            resp_ppn     <= '0;
            resp_fault   <= 1'b1;
            resp_timeout <= 1'b1;
            state        <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb_miss_controller.sv
// Scenario bench for tlb_miss_controller with a scripted page-table responder and a
// response scoreboard.
module tb_tlb_miss_controller;
  localparam int VPN_W      = 6;
  localparam int PPN_W      = 2;
  localparam int PT_TIMEOUT = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cpu_req_valid = 1'b0;
  logic             cpu_req_write = 1'b0;
  logic [VPN_W-1:0] cpu_vpn = '0;
  logic             tlb_flush = 1'b0;
  logic             cpu_req_ready, resp_valid, resp_fault, resp_timeout;
  logic [PPN_W-1:0] resp_ppn;

  always #5 clk = ~clk;

  tlb_miss_controller_if #(.VPN_W(VPN_W), .PPN_W(PPN_W)) pt_if ();

  tlb_miss_controller #(
    .TLB_ENTRIES(4), .VPN_W(VPN_W), .PPN_W(PPN_W), .PT_TIMEOUT(PT_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_write (cpu_req_write),
    .cpu_vpn       (cpu_vpn),
    .tlb_flush     (tlb_flush),
    .cpu_req_ready (cpu_req_ready),
    .resp_valid    (resp_valid),
    .resp_ppn      (resp_ppn),
    .resp_fault    (resp_fault),
    .resp_timeout  (resp_timeout),
    .pt            (pt_if)
  );

  typedef struct {
    logic [PPN_W-1:0] ppn;
    logic             fault;
    logic             timeout;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   resp_cnt = 0;
  logic prev_rv = 1'b0;

  // Page table contents: returns {fault, ppn}
  function automatic logic [PPN_W:0] pt_model(input logic [VPN_W-1:0] v);
    case (v)
      6'd0:    return {1'b0, 2'd1};
      6'd1:    return {1'b0, 2'd3};
      6'd2:    return {1'b1, 2'd0};
      6'd3:    return {1'b0, 2'd0};
      6'd4:    return {1'b0, 2'd2};
      6'd5:    return {1'b0, 2'd1};
      default: return {1'b0, v[1:0]};
    endcase
  endfunction

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (prev_rv) begin
        errors++;
        $display("FAIL resp_width: resp_valid high for more than one cycle");
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got ppn=%0d fault=%0b to=%0b, required no response",
                 resp_ppn, resp_fault, resp_timeout);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({resp_ppn, resp_fault, resp_timeout} !== {e.ppn, e.fault, e.timeout}) begin
          errors++;
          $display("FAIL resp_data: got ppn=%0d fault=%0b to=%0b, required ppn=%0d fault=%0b to=%0b",
                   resp_ppn, resp_fault, resp_timeout, e.ppn, e.fault, e.timeout);
        end
      end
      resp_cnt++;
    end
    prev_rv = resp_valid;
  end

  task automatic send_req(input logic [VPN_W-1:0] vpn, input logic wr, input logic hit,
                          input logic [PPN_W-1:0] ppn, input logic fault,
                          input logic to, input bit push);
    bit rdy;
    exp_t e;
    rdy = 1'b0;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_vpn       = vpn;
    cpu_req_write = wr;
    for (int k = 0; k < 20; k++) begin
      if (cpu_req_ready) begin rdy = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL req_ready: vpn=%0d not accepted, ready=%0b required 1", vpn, cpu_req_ready);
    end
    if (push) begin
      e.ppn = ppn; e.fault = fault; e.timeout = to;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== hit) begin
      errors++;
      $display("FAIL hit_latency: vpn=%0d resp_valid=%0b one cycle after accept, required %0b",
               vpn, resp_valid, hit);
    end
  endtask

  task automatic pt_serve(input logic rw, input logic [VPN_W-1:0] vpn,
                          input logic dwb, input logic rwb);
    bit found;
    logic [PPN_W:0] d;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pt_if.read_write_PT === rw && pt_if.virtual_page_tag === vpn) begin
        found = 1'b1; break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pt_request: rw=%0b tag=%0d, required rw=%0b tag=%0d",
               pt_if.read_write_PT, pt_if.virtual_page_tag, rw, vpn);
    end
    if (rw) begin
      checks++;
      if ({pt_if.dirty_write_back, pt_if.reference_write_back} !== {dwb, rwb}) begin
        errors++;
        $display("FAIL wb_bits: dirty=%0b ref=%0b, required dirty=%0b ref=%0b",
                 pt_if.dirty_write_back, pt_if.reference_write_back, dwb, rwb);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pt_if.read_write_PT !== rw || pt_if.virtual_page_tag !== vpn) begin
      errors++;
      $display("FAIL pt_stable: rw=%0b tag=%0d while waiting, required rw=%0b tag=%0d",
               pt_if.read_write_PT, pt_if.virtual_page_tag, rw, vpn);
    end
    d = pt_model(vpn);
    pt_if.physical_page_tag = d[PPN_W-1:0];
    pt_if.page_fault        = d[PPN_W];
    pt_if.dirty_fetched     = 1'b0;
    pt_if.reference_fetched = 1'b1;
    pt_if.PT_done           = 1'b1;
    @(negedge clk);
    pt_if.PT_done = 1'b0;
  endtask

  task automatic wait_resp(input int n0, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (resp_cnt > n0) begin seen = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no response within 60 cycles, required one", name);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_req_ready, resp_valid, resp_ppn, resp_fault, resp_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_cpu_outs: ready=%0b rv=%0b ppn=%0d fault=%0b to=%0b, required all 0",
               cpu_req_ready, resp_valid, resp_ppn, resp_fault, resp_timeout);
    end
    checks++;
    if ({pt_if.read_write_PT, pt_if.virtual_page_tag, pt_if.dirty_write_back,
         pt_if.reference_write_back} !== '0) begin
      errors++;
      $display("FAIL reset_pt_outs: rw=%0b tag=%0d dwb=%0b rwb=%0b, required all 0",
               pt_if.read_write_PT, pt_if.virtual_page_tag, pt_if.dirty_write_back,
               pt_if.reference_write_back);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: ready=%0b, required 1", cpu_req_ready);
    end
  endtask

  task automatic test_cold_miss();
    int n0 = resp_cnt;
    send_req(6'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    pt_serve(1'b0, 6'd0, 1'b0, 1'b0);
    wait_resp(n0, "cold_miss");
  endtask

  task automatic test_hit();
    int n0 = resp_cnt;
    send_req(6'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    wait_resp(n0, "hit");
  endtask

  task automatic test_fault();
    for (int r = 0; r < 2; r++) begin
      int n0 = resp_cnt;
      send_req(6'd2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
      pt_serve(1'b0, 6'd2, 1'b0, 1'b0);
      wait_resp(n0, "fault");
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    tlb_flush     = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_vpn       = 6'd0;
    #1;
    checks++;
    if (cpu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: ready=%0b during flush, required 0", cpu_req_ready);
    end
    @(negedge clk);
    tlb_flush     = 1'b0;
    cpu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: ready=%0b after flush, required 1", cpu_req_ready);
    end
  endtask

  task automatic test_back_to_back_writeback();
    logic [VPN_W-1:0] fills [4] = '{6'd4, 6'd0, 6'd3, 6'd5};
    int n0;
    // vpn0 must miss here: the flush emptied the TLB
    foreach (fills[i]) begin
      logic [PPN_W:0] d;
      d  = pt_model(fills[i]);
      n0 = resp_cnt;
      send_req(fills[i], 1'b0, 1'b0, d[PPN_W-1:0], 1'b0, 1'b0, 1'b1);
      pt_serve(1'b0, fills[i], 1'b0, 1'b0);
      wait_resp(n0, "fill");
    end
    n0 = resp_cnt;
    send_req(6'd4, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    wait_resp(n0, "write_hit");
    n0 = resp_cnt;
    send_req(6'd1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    pt_serve(1'b1, 6'd4, 1'b1, 1'b1);
    pt_serve(1'b0, 6'd1, 1'b0, 1'b0);
    wait_resp(n0, "wb_fetch");
  endtask

  task automatic test_timeout();
    int n0, lat;
    bit seen;
    seen = 1'b0;
    lat  = 0;
    n0   = resp_cnt;
    send_req(6'd6, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (resp_cnt > n0) begin seen = 1'b1; lat = k; break; end
    end
    checks++;
    if (!seen || lat < PT_TIMEOUT - 12 || lat > PT_TIMEOUT + 8) begin
      errors++;
      $display("FAIL timeout_latency: seen=%0b after %0d cycles, required about %0d",
               seen, lat, PT_TIMEOUT);
    end
    // vpn0 was the victim candidate; it must still hit
    n0 = resp_cnt;
    send_req(6'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    wait_resp(n0, "after_timeout_hit");
  endtask

  task automatic test_reset_mid();
    int n0;
    send_req(6'd7, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_req_ready, resp_valid, resp_ppn, resp_fault, resp_timeout,
         pt_if.read_write_PT, pt_if.virtual_page_tag} !== '0) begin
      errors++;
      $display("FAIL reset_mid: ready=%0b rv=%0b ppn=%0d tag=%0d, required all 0",
               cpu_req_ready, resp_valid, resp_ppn, pt_if.virtual_page_tag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = resp_cnt;
    send_req(6'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    pt_serve(1'b0, 6'd0, 1'b0, 1'b0);
    wait_resp(n0, "post_reset_miss");
  endtask

  initial begin
    pt_if.physical_page_tag = '0;
    pt_if.page_fault        = 1'b0;
    pt_if.PT_done           = 1'b0;
    pt_if.dirty_fetched     = 1'b0;
    pt_if.reference_fetched = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_fault();
    test_flush();
    test_back_to_back_writeback();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
